// File: rtl/magma_core.sv
// Iterative Magma 64-bit block cipher, one Feistel round per clock, 32 rounds per block.
// Latency 32 cycles from accepted start to done; start is ignored while busy.

module s_box (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  localparam logic [3:0] PI [8][16] = '{
    '{4'hC, 4'h4, 4'h6, 4'h2, 4'hA, 4'h5, 4'hB, 4'h9, 4'hE, 4'h8, 4'hD, 4'h7, 4'h0, 4'h3, 4'hF, 4'h1},
    '{4'h6, 4'h8, 4'h2, 4'h3, 4'h9, 4'hA, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hB, 4'hD, 4'h0, 4'hF},
    '{4'hB, 4'h3, 4'h5, 4'h8, 4'h2, 4'hF, 4'hA, 4'hD, 4'hE, 4'h1, 4'h7, 4'h4, 4'hC, 4'h9, 4'h6, 4'h0},
    '{4'hC, 4'h8, 4'h2, 4'h1, 4'hD, 4'h4, 4'hF, 4'h6, 4'h7, 4'h0, 4'hA, 4'h5, 4'h3, 4'hE, 4'h9, 4'hB},
    '{4'h7, 4'hF, 4'h5, 4'hA, 4'h8, 4'h1, 4'h6, 4'hD, 4'h0, 4'h9, 4'h3, 4'hE, 4'hB, 4'h4, 4'h2, 4'hC},
    '{4'h5, 4'hD, 4'hF, 4'h6, 4'h9, 4'h2, 4'hC, 4'hA, 4'hB, 4'h7, 4'h8, 4'h1, 4'h4, 4'h3, 4'hE, 4'h0},
    '{4'h8, 4'hE, 4'h2, 4'h5, 4'h6, 4'h9, 4'h1, 4'hC, 4'hF, 4'h4, 4'hB, 4'h0, 4'hD, 4'hA, 4'h3, 4'h7},
    '{4'h1, 4'h7, 4'hE, 4'hD, 4'h0, 4'h5, 4'h8, 4'h3, 4'h4, 4'hF, 4'hA, 4'h6, 4'h9, 4'hC, 4'hB, 4'h2}
  };

  // Table i substitutes nibble i, counting from the least significant end.
  always_comb begin
    dout = '0;
    for (int i = 0; i < 8; i++) begin
      dout[4*i +: 4] = PI[i][din[4*i +: 4]];
    end
  end

endmodule

module magma_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         decrypt,
  input  logic [255:0] key,
  input  logic [63:0]  idata,
  output logic [63:0]  odata,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state;
  logic [4:0]   rnd;
  logic [255:0] kreg;
  logic [31:0]  a1;
  logic [31:0]  a0;
  logic         dec;

  logic [2:0]   j;
  logic [7:0]   kofs;
  logic [31:0]  rk;
  logic [31:0]  sum;
  logic [31:0]  sb;
  logic [31:0]  f;

  // Forward schedule K1..K8 x3 then K8..K1; the inverse uses the mirror order.
  always_comb begin
    if (dec) begin
      j = (rnd < 5'd8) ? rnd[2:0] : (3'd7 - rnd[2:0]);
    end else begin
      j = (rnd < 5'd24) ? rnd[2:0] : (3'd7 - rnd[2:0]);
    end
  end

  assign kofs = {~j, 5'd0};
  assign rk   = kreg[kofs +: 32];
  assign sum  = a0 + rk;

  s_box u_sbox (
    .din  (sum),
    .dout (sb)
  );

  assign f = {sb[20:0], sb[31:21]} ^ a1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rnd   <= '0;
      kreg  <= '0;
      a1    <= '0;
      a0    <= '0;
      dec   <= 1'b0;
      odata <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            kreg  <= key;
            dec   <= decrypt;
            a1    <= idata[63:32];
            a0    <= idata[31:0];
            rnd   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (rnd == 5'd31) begin
            odata <= {f, a0};
            rnd   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            a1  <= a0;
            a0  <= f;
            rnd <= rnd + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_magma_core.sv
// Directed bench for magma_core: vector table plus corner-case sequences.
// Wrap-around case is checked against a behavioural cipher model.

module tb_magma_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         decrypt;
  logic [255:0] key;
  logic [63:0]  idata;
  logic [63:0]  odata;
  logic         busy;
  logic         done;

  int nvec = 0;
  int nerr = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;

  magma_core dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .decrypt (decrypt),
    .key     (key),
    .idata   (idata),
    .odata   (odata),
    .busy    (busy),
    .done    (done)
  );

  localparam logic [255:0] KEY_A  = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [63:0]  PT_A   = 64'hfedcba9876543210;
  localparam logic [63:0]  CT_A   = 64'h4ee901e5c2d8ca3d;
  localparam logic [255:0] KEY_1S = {256{1'b1}};
  localparam logic [63:0]  PT_1S  = 64'hffffffffffffffff;

  // Substitution rows written first-entry-in-top-nibble.
  localparam logic [63:0] ROWS [8] = '{
    64'hC462A5B9E8D703F1, 64'h68239A5C1E47BD0F, 64'hB3582FADE174C960, 64'hC821D4F670A53E9B,
    64'h7F5A816D093EB42C, 64'h5DF692CAB78143E0, 64'h8E25691CF4B0DA37, 64'h17ED05834FA69CB2
  };

  function automatic logic [31:0] model_g(input logic [31:0] x, input logic [31:0] k);
    logic [31:0] s;
    logic [31:0] t;
    logic [63:0] row;
    logic [3:0]  v;
    s = x + k;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      row = ROWS[i];
      v = s[4*i +: 4];
      row = row >> (4 * (15 - int'(v)));
      t[4*i +: 4] = row[3:0];
    end
    return (t << 11) | (t >> 21);
  endfunction

  function automatic logic [63:0] model(input logic [255:0] k, input logic [63:0] d, input bit dc);
    logic [31:0] kk [8];
    logic [31:0] fwd [32];
    logic [31:0] ks [32];
    logic [31:0] x1, x0, t;
    for (int i = 0; i < 8; i++) kk[i] = k[255 - 32*i -: 32];
    for (int i = 0; i < 32; i++) fwd[i] = (i < 24) ? kk[i % 8] : kk[31 - i];
    for (int i = 0; i < 32; i++) ks[i] = dc ? fwd[31 - i] : fwd[i];
    x1 = d[63:32];
    x0 = d[31:0];
    for (int i = 0; i < 31; i++) begin
      t  = model_g(x0, ks[i]) ^ x1;
      x1 = x0;
      x0 = t;
    end
    return {model_g(x0, ks[31]) ^ x1, x0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issues one block and waits for done; lat = -1 if done never arrives.
  task automatic run_block(input logic [255:0] k, input logic [63:0] d, input bit dc,
                           output logic [63:0] res, output int lat, output int busy_bad);
    key = k; idata = d; decrypt = dc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    busy_bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      if (!busy) busy_bad++;
      @(posedge clk); #1;
    end
    res = odata;
  endtask

  typedef struct {
    string        name;
    logic [255:0] k;
    logic [63:0]  d;
    bit           dc;
    logic [63:0]  exp;
  } vec_t;

  vec_t        tv [3];
  logic [63:0] res;
  logic [63:0] ones_ct;
  int          lat;
  int          bb;
  int          dc0;

  initial begin
    tv[0] = '{"enc_vec", KEY_A, PT_A, 1'b0, CT_A};
    tv[1] = '{"dec_vec", KEY_A, CT_A, 1'b1, PT_A};
    tv[2] = '{"enc_ones", KEY_1S, PT_1S, 1'b0, model(KEY_1S, PT_1S, 1'b0)};

    rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; key = '0; idata = '0;
    @(posedge clk); #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_odata", odata, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      run_block(tv[i].k, tv[i].d, tv[i].dc, res, lat, bb);
      chk({tv[i].name, "_lat"}, 64'(lat), 64'd32);
      chk({tv[i].name, "_odata"}, res, tv[i].exp);
      chk({tv[i].name, "_busy_run"}, 64'(bb), 64'd0);
      chk({tv[i].name, "_busy_done"}, {63'd0, busy}, 64'd0);
      ones_ct = res;
      @(posedge clk); #1;
      chk({tv[i].name, "_done_pulse"}, {63'd0, done}, 64'd0);
      chk({tv[i].name, "_odata_hold"}, odata, tv[i].exp);
    end

    // Carry-discard round trip back to all ones.
    run_block(KEY_1S, ones_ct, 1'b1, res, lat, bb);
    chk("ones_roundtrip", res, PT_1S);

    // Start pulses and input changes mid-run must not disturb the block.
    @(posedge clk); #1;
    dc0 = done_cnt;
    key = KEY_A; idata = PT_A; decrypt = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      if (done && lat < 0) lat = c;
      if (c == 5 || c == 20) begin start = 1'b1; idata = 64'h0123456789abcdef; decrypt = 1'b1; end
      else start = 1'b0;
      if (c == 10) key = KEY_1S;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("prot_lat", 64'(lat), 64'd32);
    chk("prot_odata", odata, CT_A);
    chk("prot_done_count", 64'(done_cnt - dc0), 64'd1);

    // Back-to-back: next start accepted in the done cycle.
    run_block(KEY_A, PT_A, 1'b0, res, lat, bb);
    chk("b2b_first", res, CT_A);
    key = KEY_A; idata = CT_A; decrypt = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      if (done) begin lat = c; break; end
      if (odata !== CT_A) begin chk("b2b_hold", odata, CT_A); break; end
      @(posedge clk); #1;
    end
    chk("b2b_lat", 64'(lat), 64'd32);
    chk("b2b_second", odata, PT_A);

    // Reset at round 17 discards the block.
    @(posedge clk); #1;
    key = KEY_A; idata = PT_A; decrypt = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_done", {63'd0, done}, 64'd0);
    chk("mrst_odata", odata, 64'd0);
    dc0 = done_cnt;
    repeat (40) @(posedge clk);
    #1;
    chk("mrst_no_done", 64'(done_cnt - dc0), 64'd0);
    run_block(KEY_A, PT_A, 1'b0, res, lat, bb);
    chk("mrst_rerun_lat", 64'(lat), 64'd32);
    chk("mrst_rerun", res, CT_A);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
